cursor_ctrl: RTL and testbench

Turns the five debounced push-button levels into tic-tac-toe board navigation and move requests. Sits directly downstream of the per-button debouncers and upstream of the game-state/referee logic. It tracks a cursor on the 3x3 grid with wrap-around and hold-to-repeat. It also issues a valid/ready move request when the select button is pressed on an empty cell.

---
 rtl/cursor_ctrl_pkg.sv | 21 ++
 rtl/btn_edge.sv | 19 +
 rtl/cursor_ctrl.sv | 149 ++++++++++++++
 tb/tb_cursor_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cursor_ctrl_pkg.sv
// Shared encodings for the tic-tac-toe cursor controller: cell constants,
// direction codes and the auto-repeat state encoding.
package cursor_ctrl_pkg;

  localparam logic [3:0] CELL_CENTRE = 4'd4;
  localparam int         NUM_CELLS   = 9;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced button level; press_o is high in the
// cycle the level first reads 1 after a 0.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic press_o
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (!rst) level_q <= 1'b0;
    else      level_q <= level_i;
  end

  assign press_o = level_i & ~level_q;

endmodule

// File: rtl/cursor_ctrl.sv
// Cursor navigation on the 3x3 board with wrap-around and hold-to-repeat,
// plus a valid/ready move request issued by the select button.
//
//   state     | meaning
//   ST_IDLE   | no direction held
//   ST_HOLD   | direction held, waiting REPEAT_DLY before auto-repeat
//   ST_REPEAT | auto-repeating every REPEAT_PER cycles
module cursor_ctrl
  import cursor_ctrl_pkg::*;
#(
  parameter logic [23:0] REPEAT_DLY = 24'd5_000_000,
  parameter logic [23:0] REPEAT_PER = 24'd2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic [8:0] occupied,
  output logic [3:0] cursor,
  output logic       move_valid,
  output logic [3:0] move_cell,
  input  logic       move_ready,
  output logic       reject
);

  logic [4:0] level;
  logic [4:0] press;
  logic [3:0] dir_level;

  assign level     = {btn_sel, btn_right, btn_left, btn_down, btn_up};
  assign dir_level = level[3:0];

  for (genvar i = 0; i < 5; i++) begin : g_edge
    btn_edge u_btn_edge (
      .clk     (clk),
      .rst     (rst),
      .level_i (level[i]),
      .press_o (press[i])
    );
  end

  rpt_state_e  state_q;
  dir_e        dir_q;
  logic [23:0] cnt_q;
  logic [3:0]  cursor_q;
  logic        move_valid_q;
  logic [3:0]  move_cell_q;
  logic        reject_q;

  logic        dir_pressed;
  dir_e        dir_new;
  logic        new_press;
  dir_e        step_dir;
  logic [1:0]  row, col, row_n, col_n;
  logic [3:0]  cell_step_d;
  logic [23:0] cnt_lim;
  logic        dir_held;

  always_comb begin
    dir_pressed = |press[3:0];
    if      (press[0]) dir_new = DIR_UP;
    else if (press[1]) dir_new = DIR_DOWN;
    else if (press[2]) dir_new = DIR_LEFT;
    else               dir_new = DIR_RIGHT;

    // A fresh press of a different direction preempts the one being held.
    new_press = dir_pressed && ((state_q == ST_IDLE) || (dir_new != dir_q));
    step_dir  = new_press ? dir_new : dir_q;
    dir_held  = dir_level[dir_q];
    cnt_lim   = (state_q == ST_HOLD) ? (REPEAT_DLY - 24'd1) : (REPEAT_PER - 24'd1);

    if      (cursor_q >= 4'd6) row = 2'd2;
    else if (cursor_q >= 4'd3) row = 2'd1;
    else                       row = 2'd0;
    col = 2'(cursor_q - 4'(row) * 4'd3);

    row_n = row;
    col_n = col;
    case (step_dir)
      DIR_UP:    row_n = (row == 2'd0) ? 2'd2 : row - 2'd1;
      DIR_DOWN:  row_n = (row == 2'd2) ? 2'd0 : row + 2'd1;
      DIR_LEFT:  col_n = (col == 2'd0) ? 2'd2 : col - 2'd1;
      DIR_RIGHT: col_n = (col == 2'd2) ? 2'd0 : col + 2'd1;
      default: ;
    endcase
    cell_step_d = 4'(row_n) * 4'd3 + 4'(col_n);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      dir_q        <= DIR_UP;
      cnt_q        <= 24'd0;
      cursor_q     <= CELL_CENTRE;
      move_valid_q <= 1'b0;
      move_cell_q  <= 4'd0;
      reject_q     <= 1'b0;
    end else begin
      reject_q <= 1'b0;
      if (move_valid_q && move_ready) move_valid_q <= 1'b0;
      // Select sees the pre-step cursor and the pre-transfer request.
      if (press[4]) begin
        if (move_valid_q || occupied[cursor_q]) begin
          reject_q <= 1'b1;
        end else begin
          move_valid_q <= 1'b1;
          move_cell_q  <= cursor_q;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (new_press) begin
            cursor_q <= cell_step_d;
            dir_q    <= dir_new;
            cnt_q    <= 24'd0;
            state_q  <= ST_HOLD;
          end
        end
        ST_HOLD, ST_REPEAT: begin
          if (new_press) begin
            cursor_q <= cell_step_d;
            dir_q    <= dir_new;
            cnt_q    <= 24'd0;
            state_q  <= ST_HOLD;
          end else if (!dir_held) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == cnt_lim) begin
            cursor_q <= cell_step_d;
            cnt_q    <= 24'd0;
            state_q  <= ST_REPEAT;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cursor     = cursor_q;
  assign move_valid = move_valid_q;
  assign move_cell  = move_cell_q;
  assign reject     = reject_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Directed bench for cursor_ctrl with a row/column behavioural model checked
// every cycle, plus literal expectations along the scripted sequence.
module tb_cursor_ctrl;

  localparam int DLY = 10;
  localparam int PER = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn;  // [0]up [1]down [2]left [3]right [4]sel
  logic [8:0] occupied;
  logic       move_ready;
  logic [3:0] cursor;
  logic       move_valid;
  logic [3:0] move_cell;
  logic       reject;

  int nvec = 0;
  int nbad = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  cursor_ctrl #(.REPEAT_DLY(24'd10), .REPEAT_PER(24'd4)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_up     (btn[0]),
    .btn_down   (btn[1]),
    .btn_left   (btn[2]),
    .btn_right  (btn[3]),
    .btn_sel    (btn[4]),
    .occupied   (occupied),
    .cursor     (cursor),
    .move_valid (move_valid),
    .move_cell  (move_cell),
    .move_ready (move_ready),
    .reject     (reject)
  );

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: cursor as (row, col), hold tracked as elapsed cycles
  // since the initial step rather than as a restarting counter.
  int m_row, m_col, m_cell, m_hdir, m_hn;
  bit m_mv, m_rej, m_held;
  bit [4:0] m_prev;
  int n_row, n_col, n_cell, n_hdir, n_hn;
  bit n_mv, n_rej, n_held;

  function automatic void mstep(input int d, inout int r, inout int c);
    case (d)
      0: r = (r + 2) % 3;
      1: r = (r + 1) % 3;
      2: c = (c + 2) % 3;
      default: c = (c + 1) % 3;
    endcase
  endfunction

  always_comb begin
    int nd;
    bit [4:0] pr;
    n_row = m_row; n_col = m_col; n_cell = m_cell; n_hdir = m_hdir; n_hn = m_hn;
    n_mv = m_mv; n_rej = 1'b0; n_held = m_held;
    nd = -1;
    pr = btn & ~m_prev;
    if (m_mv && move_ready) n_mv = 1'b0;
    if (pr[4]) begin
      if (m_mv || occupied[m_row*3 + m_col]) n_rej = 1'b1;
      else begin n_mv = 1'b1; n_cell = m_row*3 + m_col; end
    end
    for (int i = 3; i >= 0; i--) if (pr[i]) nd = i;
    if (nd >= 0 && (!m_held || nd != m_hdir)) begin
      mstep(nd, n_row, n_col);
      n_held = 1'b1; n_hdir = nd; n_hn = 0;
    end else if (m_held) begin
      if (!btn[m_hdir]) n_held = 1'b0;
      else begin
        n_hn = m_hn + 1;
        if (n_hn == DLY || (n_hn > DLY && (n_hn - DLY) % PER == 0))
          mstep(m_hdir, n_row, n_col);
      end
    end
  end

  always @(posedge clk) begin
    started <= 1'b1;
    if (!rst) begin
      m_row <= 1; m_col <= 1; m_mv <= 1'b0; m_cell <= 0; m_rej <= 1'b0;
      m_held <= 1'b0; m_hdir <= 0; m_hn <= 0; m_prev <= 5'b0;
    end else begin
      m_row <= n_row; m_col <= n_col; m_mv <= n_mv; m_cell <= n_cell;
      m_rej <= n_rej; m_held <= n_held; m_hdir <= n_hdir; m_hn <= n_hn;
      m_prev <= btn;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_cursor", int'(cursor), m_row*3 + m_col);
      check("model_move_valid", int'(move_valid), int'(m_mv));
      check("model_move_cell", int'(move_cell), m_cell);
      check("model_reject", int'(reject), int'(m_rej));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    tick(1);
    btn[b] = 1'b0;
    tick(2);
  endtask

  function automatic int hold_exp(input int k);
    if (k < 10) return 7;
    if (k < 14) return 1;
    if (k < 18) return 4;
    if (k < 22) return 7;
    if (k < 26) return 1;
    return 4;
  endfunction

  initial begin
    rst = 1'b0; btn = 5'b0; occupied = 9'b0; move_ready = 1'b0;
    tick(3);
    check("reset_cursor", int'(cursor), 4);
    check("reset_move_valid", int'(move_valid), 0);
    check("reset_move_cell", int'(move_cell), 0);
    check("reset_reject", int'(reject), 0);
    rst = 1'b1;
    tick(2);

    btn[3] = 1'b1; tick(1); check("right1", int'(cursor), 5); btn[3] = 1'b0; tick(2);
    btn[3] = 1'b1; tick(1); check("right2_wrap", int'(cursor), 3); btn[3] = 1'b0; tick(2);
    btn[3] = 1'b1; tick(1); check("right3", int'(cursor), 4); btn[3] = 1'b0; tick(2);
    check("right_no_move", int'(move_valid), 0);

    press(0); press(2);
    check("at_cell0", int'(cursor), 0);
    press(0); check("up_wrap_from0", int'(cursor), 6);
    press(2); check("left_wrap_from6", int'(cursor), 8);

    press(0); press(2);
    check("back_to_4", int'(cursor), 4);
    btn[1] = 1'b1;
    tick(1);
    check("hold_step0", int'(cursor), 7);
    for (int k = 1; k < 30; k++) begin
      tick(1);
      check($sformatf("hold_k%0d", k), int'(cursor), hold_exp(k));
    end
    btn[1] = 1'b0;
    tick(10);
    check("hold_release", int'(cursor), 4);

    occupied = 9'b000010000;
    btn[4] = 1'b1; tick(1);
    check("sel_occ_reject", int'(reject), 1);
    check("sel_occ_no_move", int'(move_valid), 0);
    btn[4] = 1'b0; tick(1);
    check("reject_one_cycle", int'(reject), 0);
    press(3);
    btn[4] = 1'b1; tick(1);
    check("sel_move_valid", int'(move_valid), 1);
    check("sel_move_cell", int'(move_cell), 5);
    btn[4] = 1'b0;
    tick(5);
    check("pending_held", int'(move_valid), 1);
    press(3);
    check("nav_while_pending", int'(cursor), 3);
    btn[4] = 1'b1; tick(1);
    check("sel_pending_reject", int'(reject), 1);
    check("pending_cell_stable", int'(move_cell), 5);
    btn[4] = 1'b0;
    move_ready = 1'b1; tick(1);
    check("handshake_clear", int'(move_valid), 0);
    move_ready = 1'b0; tick(2);

    press(3);
    check("before_coincide", int'(cursor), 4);
    btn[0] = 1'b1; btn[2] = 1'b1; tick(1);
    check("up_left_priority", int'(cursor), 1);
    btn[0] = 1'b0; btn[2] = 1'b0; tick(2);

    btn[3] = 1'b1; tick(1);
    check("hold_right", int'(cursor), 2);
    tick(3);
    rst = 1'b0; tick(1);
    check("midhold_reset", int'(cursor), 4);
    btn[3] = 1'b0; tick(1);
    rst = 1'b1; tick(3);
    check("after_reset_idle", int'(cursor), 4);
    btn[1] = 1'b1; tick(1);
    check("post_reset_step", int'(cursor), 7);
    tick(9);
    check("post_reset_counter", int'(cursor), 7);
    tick(1);
    check("post_reset_repeat", int'(cursor), 1);
    btn[1] = 1'b0; tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
